poly_fir_stage2: RTL and testbench

POLY_FIR_STAGE2 -- requirements
Module: poly_fir_stage2

---
 rtl/poly_fir_stage2.sv | 101 ++++++++++
 tb/tb_poly_fir_stage2.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/poly_fir_stage2.sv
// poly_fir_stage2: decimating FIR, one shared registered multiplier stepping through the taps
module poly_fir_stage2 #(
  parameter int DECIMATION_FACTOR = 2,
  parameter int TAP_LEN = 32,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_SHIFT = 15,
  parameter logic [TAP_LEN*COEF_WIDTH-1:0] COEFS = {
    {(TAP_LEN/4){COEF_WIDTH'(16384/TAP_LEN)}},
    {(TAP_LEN/2){COEF_WIDTH'(3*16384/TAP_LEN)}},
    {(TAP_LEN/4){COEF_WIDTH'(16384/TAP_LEN)}}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  overrun
);
  localparam int TW = $clog2(TAP_LEN);
  localparam int BW = TW + 1;
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam int AW = PW + TW;
  localparam int CW = DECIMATION_FACTOR > 1 ? $clog2(DECIMATION_FACTOR) : 1;
  localparam logic [CW-1:0] PH_LAST = CW'(DECIMATION_FACTOR - 1);
  localparam logic signed [AW-1:0] RND = AW'(1) << (COEF_SHIFT - 1);
  localparam logic signed [AW-1:0] SMAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [2*TAP_LEN];
  logic [BW-1:0] wp, snap, ra;
  logic [TW-1:0] cnt;
  logic [CW-1:0] ph;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc, scaled;
  logic signed [DATA_WIDTH-1:0] xk;
  logic signed [COEF_WIDTH-1:0] hk;
  logic [DATA_WIDTH-1:0] sat;
  logic pv, oq, trig;
  assign trig = din_valid && ph == PH_LAST;
  assign ra = snap - BW'(cnt);
  always_comb begin
    xk = $signed(mem[ra]);
    hk = $signed(COEFS[cnt*COEF_WIDTH +: COEF_WIDTH]);
    scaled = (acc + RND) >>> COEF_SHIFT;
    sat = scaled > SMAX ? SMAX[DATA_WIDTH-1:0] : scaled < SMIN ? SMIN[DATA_WIDTH-1:0] : scaled[DATA_WIDTH-1:0];
  end
  // product lags the tap counter by one cycle, accumulator by two; FLUSH drains the last tap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mem <= '{default: '0};
      wp <= '0;
      snap <= '0;
      cnt <= '0;
      ph <= '0;
      prod <= '0;
      acc <= '0;
      pv <= 1'b0;
      oq <= 1'b0;
      dout <= '0;
      dout_valid <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (din_valid) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
        ph <= trig ? '0 : ph + 1'b1;
      end
      overrun <= trig && state != IDLE;
      prod <= PW'(xk) * PW'(hk);
      pv <= state == MAC;
      oq <= state == OUT;
      dout_valid <= oq;
      if (oq) dout <= sat;
      if (pv) acc <= acc + AW'(prod);
      case (state)
        IDLE: if (trig) begin
          state <= MAC;
          snap <= wp;
          cnt <= '0;
          acc <= '0;
          busy <= 1'b1;
        end
        MAC: begin
          cnt <= cnt + 1'b1;
          if (cnt == TW'(TAP_LEN - 1)) state <= FLUSH;
        end
        FLUSH: state <= OUT;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_poly_fir_stage2.sv
// tb_poly_fir_stage2: three coefficient sets share one input stream; each output is scored
// against a direct tap sum over the sample history, plus fixed expected values per scenario
module tb_poly_fir_stage2;
  logic clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0;
  logic [15:0] din = '0;
  logic dv [3], bz [3], ov [3];
  logic [15:0] dq [3];
  typedef struct packed { logic [31:0] e; logic [2:0][31:0] y; } exp_t;
  exp_t sb [$];
  int hist [$];
  int checks = 0, errors = 0, cyc = 0, ph = 0, busy_end = 0, ov_edge = -1;
  int hold [3];
  int spot [3];
  bit spot_on [3];
  bit armed = 1'b0, done = 1'b0, fin = 1'b0;

  function automatic int coef(int s, int k);
    if (s == 0) return 1000 * (k + 1);
    if (s == 1) return k == 0 ? 16384 : 0;
    return (k >= 8 && k < 24) ? 1536 : 512;
  endfunction

  function automatic logic [511:0] pack(int s);
    logic [511:0] v;
    for (int k = 0; k < 32; k++) v[k*16 +: 16] = 16'(coef(s, k));
    return v;
  endfunction

  localparam logic [511:0] CA = pack(0);
  localparam logic [511:0] CB = pack(1);

  function automatic int fir(int s);
    longint a;
    a = 0;
    for (int k = 0; k < 32; k++) a += longint'(coef(s, k)) * longint'(hist[k]);
    a = (a + 16384) >>> 15;
    return a > 32767 ? 32767 : a < -32768 ? -32768 : int'(a);
  endfunction

  poly_fir_stage2 #(.COEFS(CA)) u_a (.clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout_valid(dv[0]), .dout(dq[0]), .busy(bz[0]), .overrun(ov[0]));
  poly_fir_stage2 #(.COEFS(CB)) u_b (.clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout_valid(dv[1]), .dout(dq[1]), .busy(bz[1]), .overrun(ov[1]));
  poly_fir_stage2 u_c (.clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout_valid(dv[2]), .dout(dq[2]), .busy(bz[2]), .overrun(ov[2]));

  always #5 clk = ~clk;

  task automatic chk(string nm, int d, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, req);
    end
  endtask

  // reference model updates on the edge, the monitor compares 1 time unit later
  always @(posedge clk) begin
    exp_t x;
    bit any;
    cyc++;
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < 32; k++) hist.push_back(0);
      sb.delete();
      ph = 0;
      busy_end = 0;
      ov_edge = -1;
      hold = '{0, 0, 0};
      armed = 1'b1;
    end else if (din_valid) begin
      hist.push_front(int'($signed(din)));
      void'(hist.pop_back());
      if (ph == 1) begin
        if (cyc > busy_end) begin
          x.e = 32'(cyc + 35);
          for (int d = 0; d < 3; d++) x.y[d] = 32'(fir(d));
          sb.push_back(x);
          busy_end = cyc + 34;
        end else ov_edge = cyc;
      end
      ph = (ph + 1) % 2;
    end
    #1;
    if (armed) begin
      any = dv[0] | dv[1] | dv[2];
      if (any && sb.size() == 0) chk("unexpected_dout_valid", 0, 1, 0);
      else if (any) begin
        x = sb.pop_front();
        chk("latency", 0, cyc, int'(x.e));
        for (int d = 0; d < 3; d++) begin
          chk("dout_valid", d, dv[d], 1);
          chk("dout", d, $signed(dq[d]), $signed(x.y[d]));
          if (spot_on[d]) chk("scenario_value", d, $signed(dq[d]), spot[d]);
          hold[d] = $signed(x.y[d]);
        end
      end else begin
        if (sb.size() > 0 && int'(sb[0].e) < cyc) begin
          chk("missing_dout_valid", 0, 0, 1);
          void'(sb.pop_front());
        end
        for (int d = 0; d < 3; d++) chk("dout_hold", d, $signed(dq[d]), hold[d]);
      end
      for (int d = 0; d < 3; d++) begin
        chk("busy", d, bz[d], cyc < busy_end);
        chk("overrun", d, ov[d], cyc == ov_edge);
      end
      if (done && !fin) begin
        chk("drained", 0, sb.size(), 0);
        fin = 1'b1;
      end
    end
  end

  task automatic send(int v, int gap);
    din_valid = 1'b1;
    din = 16'(v);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic impulse();
    send(32767, 20);
    repeat (39) send(0, 20);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, v;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    impulse();
    for (int i = 0; i < 40; i++) begin
      if (i == 34) begin spot[2] = 1000; spot_on[2] = 1'b1; end
      send(1000, 20);
    end
    idle(40);
    spot_on[2] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin spot[0] = 32767; spot_on[0] = 1'b1; end
      send(32767, 20);
    end
    idle(40);
    spot_on[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 30) begin spot[0] = -32768; spot_on[0] = 1'b1; end
      send(-32768, 20);
    end
    idle(40);
    spot_on[0] = 1'b0;
    spot[1] = 2;
    spot_on[1] = 1'b1;
    repeat (6) begin send(0, 20); send(3, 20); end
    idle(40);
    spot[1] = -1;
    repeat (6) begin send(0, 20); send(-3, 20); end
    idle(40);
    spot_on[1] = 1'b0;
    repeat (8) send(500, 5);
    idle(40);
    send(32767, 20);
    send(0, 10);
    din_valid = 1'b1;
    din = 16'd12345;
    pulse_reset();
    din_valid = 1'b0;
    idle(40);
    impulse();
    idle(40);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      v = r == 0 ? 32767 : r == 1 ? -32768 : int'($signed(16'($urandom)));
      if ($urandom_range(0, 99) == 0) pulse_reset();
      send(v, $urandom_range(1, 25));
    end
    idle(60);
    done = 1'b1;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
